// File: rtl/arduino_digit_receiver_pkg.sv
// Shared definitions for the FPGA-to-Arduino digit link: link timing,
// receiver FSM states and error cause encoding.
package arduino_digit_receiver_pkg;

   // Nominal strobe-high and gap-low length in hwclk cycles (1/10 s).
   localparam int unsigned HOLD_TIME = 1200000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_QUAL,
      ST_HOLD,
      ST_STUCK,
      ST_GAP
   } rx_state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RUNT     = 2'b01;
   localparam logic [1:0] ERR_UNSTABLE = 2'b10;
   localparam logic [1:0] ERR_STUCK    = 2'b11;

endpackage

// File: rtl/arduino_digit_receiver_sync2.sv
// Two-flop synchroniser for one asynchronous link line.
module arduino_digit_receiver_sync2 (
   input  logic hwclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/arduino_digit_receiver.sv
// Digit link receiver: qualifies strobe width and data stability, latches
// each digit and assembles CODE_LEN digits into a keylock code word.
//
//   state | meaning
//   IDLE  | waiting for strobe high; data captured on its arrival
//   QUAL  | strobe high, timing MIN_HIGH with data held steady
//   HOLD  | digit accepted, waiting for strobe low (stuck watchdog armed)
//   STUCK | strobe exceeded MAX_HIGH, waiting for it to drop
//   GAP   | strobe low must persist MIN_LOW cycles; any high restarts it
module arduino_digit_receiver #(
   parameter int unsigned HOLD_TIME = arduino_digit_receiver_pkg::HOLD_TIME,
   parameter int unsigned MIN_HIGH  = HOLD_TIME / 2,
   parameter int unsigned MAX_HIGH  = HOLD_TIME * 2,
   parameter int unsigned MIN_LOW   = HOLD_TIME / 2,
   parameter int unsigned CODE_LEN  = 4
) (
   input  logic                              hwclk,
   input  logic                              rst_n,
   input  logic                              in0,
   input  logic                              in1,
   input  logic                              in2,
   input  logic                              controlIn,
   input  logic                              clear,
   output logic [3:0]                        num,
   output logic                              valid,
   output logic [3*CODE_LEN-1:0]             code,
   output logic                              code_valid,
   output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
   output logic                              error,
   output logic [1:0]                        err_code
);
   import arduino_digit_receiver_pkg::*;

   localparam int CW = $clog2(CODE_LEN + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CODE_LEN - 1);

   // Down-counter reload values; terminal count is zero.  The stuck value is
   // one past MAX_HIGH so the error fires only once the high time exceeds it.
   localparam logic [31:0] T_MIN_HIGH = 32'(MIN_HIGH);
   localparam logic [31:0] T_STUCK    = 32'(MAX_HIGH + 1);
   localparam logic [31:0] T_MIN_LOW  = 32'(MIN_LOW);

   logic [3:0] raw;
   logic [3:0] synced;
   logic [2:0] data_s;
   logic       ctrl_s;

   assign raw    = {controlIn, in2, in1, in0};
   assign data_s = synced[2:0];
   assign ctrl_s = synced[3];

   for (genvar i = 0; i < 4; i++) begin : g_sync
      arduino_digit_receiver_sync2 u_sync (
         .hwclk (hwclk),
         .rst_n (rst_n),
         .d     (raw[i]),
         .q     (synced[i])
      );
   end

   rx_state_t   state;
   logic [31:0] tmr;
   logic [2:0]  d_cap;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         tmr         <= '0;
         d_cap       <= '0;
         num         <= '0;
         valid       <= 1'b0;
         code        <= '0;
         code_valid  <= 1'b0;
         digit_count <= '0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         valid      <= 1'b0;
         code_valid <= 1'b0;
         error      <= 1'b0;
         if (clear) digit_count <= '0;

         case (state)
            ST_IDLE: begin
               if (ctrl_s) begin
                  d_cap <= data_s;
                  tmr   <= T_MIN_HIGH;
                  state <= ST_QUAL;
               end
            end

            ST_QUAL: begin
               if (!ctrl_s) begin
                  error       <= 1'b1;
                  err_code    <= ERR_RUNT;
                  digit_count <= '0;
                  tmr         <= T_MIN_LOW;
                  state       <= ST_GAP;
               end else if (data_s != d_cap) begin
                  error       <= 1'b1;
                  err_code    <= ERR_UNSTABLE;
                  digit_count <= '0;
                  tmr         <= T_MIN_LOW;
                  state       <= ST_GAP;
               end else if (tmr == '0) begin
                  num   <= {1'b0, d_cap};
                  valid <= 1'b1;
                  code  <= {code[3*CODE_LEN-4:0], d_cap};
                  // clear takes precedence over the count update
                  if (!clear) begin
                     if (digit_count == CNT_LAST) begin
                        digit_count <= '0;
                        code_valid  <= 1'b1;
                     end else begin
                        digit_count <= digit_count + CNT_ONE;
                     end
                  end
                  tmr   <= T_STUCK;
                  state <= ST_HOLD;
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end

            ST_HOLD: begin
               if (!ctrl_s) begin
                  tmr   <= T_MIN_LOW;
                  state <= ST_GAP;
               end else if (tmr == '0) begin
                  error       <= 1'b1;
                  err_code    <= ERR_STUCK;
                  digit_count <= '0;
                  state       <= ST_STUCK;
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end

            ST_STUCK: begin
               if (!ctrl_s) begin
                  tmr   <= T_MIN_LOW;
                  state <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (ctrl_s) begin
                  tmr <= T_MIN_LOW;
               end else if (tmr == '0) begin
                  state <= ST_IDLE;
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arduino_digit_receiver.sv
// Directed bench for the digit link receiver with HOLD_TIME=20.
module tb_arduino_digit_receiver;

   logic        hwclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in0 = 1'b0, in1 = 1'b0, in2 = 1'b0;
   logic        controlIn = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  num;
   logic        valid;
   logic [11:0] code;
   logic        code_valid;
   logic [2:0]  digit_count;
   logic        error;
   logic [1:0]  err_code;

   arduino_digit_receiver #(.HOLD_TIME(20), .CODE_LEN(4)) dut (
      .hwclk       (hwclk),
      .rst_n       (rst_n),
      .in0         (in0),
      .in1         (in1),
      .in2         (in2),
      .controlIn   (controlIn),
      .clear       (clear),
      .num         (num),
      .valid       (valid),
      .code        (code),
      .code_valid  (code_valid),
      .digit_count (digit_count),
      .error       (error),
      .err_code    (err_code)
   );

   always #5 hwclk = ~hwclk;

   int cyc = 0;
   always @(posedge hwclk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   int n_valid, n_cv, n_err;
   int cyc_valid, cyc_err, rise_cyc;
   int last_num, last_code, last_err, cv_on_valid;
   int nums[$];

   always @(negedge hwclk) begin
      if (valid) begin
         n_valid++;
         last_num = 32'(num);
         nums.push_back(32'(num));
         if (n_valid == 1) cyc_valid = cyc;
      end
      if (code_valid) begin
         n_cv++;
         last_code   = 32'(code);
         cv_on_valid = 32'(valid);
      end
      if (error) begin
         n_err++;
         last_err = 32'(err_code);
         if (n_err == 1) cyc_err = cyc;
      end
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge hwclk);
         #2;
      end
   endtask

   task automatic clr_mon();
      n_valid = 0; n_cv = 0; n_err = 0;
      cyc_valid = -1; cyc_err = -1;
      last_num = -1; last_code = -1; last_err = -1; cv_on_valid = -1;
      nums.delete();
   endtask

   task automatic start_strobe(input logic [2:0] d);
      {in2, in1, in0} = d;
      controlIn = 1'b1;
      rise_cyc  = cyc + 1;
   endtask

   task automatic send_digit(input logic [2:0] d, input int hi, input int lo);
      start_strobe(d);
      tick(hi);
      controlIn = 1'b0;
      tick(lo);
   endtask

   initial begin
      clr_mon();
      tick(3);
      check_val("rst_num",   32'(num), 0);
      check_val("rst_flags", 32'({valid, code_valid, error}), 0);
      check_val("rst_code",  32'(code), 0);
      check_val("rst_cnt",   32'(digit_count), 0);
      check_val("rst_err",   32'(err_code), 0);
      rst_n = 1'b1;
      tick(3);

      // 1: four clean digits 3,1,4,6 form code 011_001_100_110
      clr_mon();
      send_digit(3'd3, 20, 20);
      check_val("lat_valid", cyc_valid - rise_cyc, 13);
      send_digit(3'd1, 20, 20);
      send_digit(3'd4, 20, 20);
      check_val("cnt3", 32'(digit_count), 3);
      send_digit(3'd6, 20, 20);
      check_val("t1_nvalid", n_valid, 4);
      check_val("t1_d0", (nums.size() > 0) ? nums[0] : -1, 3);
      check_val("t1_d1", (nums.size() > 1) ? nums[1] : -1, 1);
      check_val("t1_d2", (nums.size() > 2) ? nums[2] : -1, 4);
      check_val("t1_d3", (nums.size() > 3) ? nums[3] : -1, 6);
      check_val("t1_ncv", n_cv, 1);
      check_val("t1_code", last_code, 'h666);
      check_val("t1_cv_with_valid", cv_on_valid, 1);
      check_val("t1_cnt", 32'(digit_count), 0);

      // 2: digit 5, then a 6-cycle runt strobe
      clr_mon();
      send_digit(3'd5, 20, 20);
      check_val("t2_cnt1", 32'(digit_count), 1);
      send_digit(3'd5, 6, 20);
      check_val("t2_nvalid", n_valid, 1);
      check_val("t2_nerr", n_err, 1);
      check_val("t2_errcode", last_err, 1);
      check_val("t2_cnt0", 32'(digit_count), 0);

      // 3: data changes mid-qualification, then a clean 2
      clr_mon();
      start_strobe(3'd3);
      tick(5);
      {in2, in1, in0} = 3'd5;
      tick(15);
      controlIn = 1'b0;
      tick(20);
      check_val("t3_nvalid", n_valid, 0);
      check_val("t3_nerr", n_err, 1);
      check_val("t3_errcode", last_err, 2);
      clr_mon();
      send_digit(3'd2, 20, 20);
      check_val("t3_num", last_num, 2);
      check_val("t3_cnt", 32'(digit_count), 1);

      // 4: strobe stuck high 60 cycles; error at 2+10+1+40+2 = 55 after rise
      clr_mon();
      send_digit(3'd1, 60, 20);
      check_val("t4_nvalid", n_valid, 1);
      check_val("t4_num", last_num, 1);
      check_val("t4_lat_valid", cyc_valid - rise_cyc, 13);
      check_val("t4_nerr", n_err, 1);
      check_val("t4_errcode", last_err, 3);
      check_val("t4_lat_err", cyc_err - rise_cyc, 55);
      check_val("t4_cnt0", 32'(digit_count), 0);
      clr_mon();
      send_digit(3'd4, 20, 20);
      check_val("t4_after", last_num, 4);

      // 5: 4-cycle gap, second strobe ignored silently
      clr_mon();
      send_digit(3'd6, 20, 4);
      send_digit(3'd5, 20, 20);
      check_val("t5_nvalid", n_valid, 1);
      check_val("t5_num", last_num, 6);
      check_val("t5_nerr", n_err, 0);
      check_val("t5_cnt", 32'(digit_count), 2);

      // 6: digit 7 accepted as-is, then reset mid-qualification
      clr_mon();
      send_digit(3'd7, 20, 20);
      check_val("t6_seven", last_num, 7);
      check_val("t6_cnt3", 32'(digit_count), 3);
      clr_mon();
      start_strobe(3'd2);
      tick(8);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_num", 32'(num), 0);
      check_val("t6_rst_cnt", 32'(digit_count), 0);
      check_val("t6_rst_code", 32'(code), 0);
      check_val("t6_rst_err", 32'(err_code), 0);
      tick(2);
      rst_n = 1'b1;
      tick(8);
      controlIn = 1'b0;
      tick(20);
      check_val("t6_nvalid", n_valid, 0);
      check_val("t6_nerr", n_err, 1);
      check_val("t6_errcode", last_err, 1);
      clr_mon();
      send_digit(3'd0, 20, 20);
      send_digit(3'd5, 20, 20);
      send_digit(3'd7, 20, 20);
      send_digit(3'd1, 20, 20);
      check_val("t6_nvalid2", n_valid, 4);
      check_val("t6_ncv", n_cv, 1);
      check_val("t6_code", last_code, 'h179);

      // clear coinciding with the 4th accept: count zeroed, code_valid held off
      clr_mon();
      send_digit(3'd1, 20, 20);
      send_digit(3'd2, 20, 20);
      send_digit(3'd3, 20, 20);
      check_val("clr_cnt3", 32'(digit_count), 3);
      start_strobe(3'd6);
      tick(13);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(6);
      controlIn = 1'b0;
      tick(20);
      check_val("clr_nvalid", n_valid, 4);
      check_val("clr_num", last_num, 6);
      check_val("clr_ncv", n_cv, 0);
      check_val("clr_cnt", 32'(digit_count), 0);
      check_val("clr_code", 32'(code), 'h29E);

      // plain clear of a partial code
      clr_mon();
      send_digit(3'd4, 20, 20);
      check_val("clr2_cnt1", 32'(digit_count), 1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(1);
      check_val("clr2_cnt0", 32'(digit_count), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arduino_digit_receiver.md
Name: arduino_digit_receiver

Overview:
Receive-side counterpart of the FPGA-to-Arduino digit link. The link uses three data lines plus one control strobe. Each digit is sent as the data held steady while control is high for one hold period, followed by control low for one hold period. This block synchronises the lines and qualifies strobe width and data stability. It latches each digit and assembles CODE_LEN digits into a keylock code word for the lock-compare logic.

Parameters:
HOLD_TIME, 1200000, nominal strobe-high and gap-low length in hwclk cycles (1/10 s).
MIN_HIGH, HOLD_TIME/2, minimum qualified strobe-high cycles.
MAX_HIGH, HOLD_TIME*2, strobe-high cycles beyond which the line is declared stuck.
MIN_LOW, HOLD_TIME/2, minimum gap-low cycles before the next strobe is accepted.
CODE_LEN, 4, digits per code word.

Ports:
hwclk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in0  input  1  data bit 0 (asynchronous)
in1  input  1  data bit 1 (asynchronous)
in2  input  1  data bit 2 (asynchronous)
controlIn  input  1  strobe (asynchronous)
clear  input  1  synchronous: discard partial code, digit_count to 0
num  output  4  last accepted digit, zero-extended
valid  output  1  1-cycle pulse, digit accepted
code  output  3*CODE_LEN  assembled code; first digit in MS 3 bits
code_valid  output  1  1-cycle pulse, code complete
digit_count  output  clog2(CODE_LEN+1)  digits held in the partial code
error  output  1  1-cycle pulse on a protocol error
err_code  output  2  cause of the last error: 01 runt, 10 data unstable, 11 stuck high

Behaviour:
- Reset is asynchronous and active-low. One clock, hwclk. While rst_n=0 all outputs are 0 and the FSM is in IDLE.
- All four inputs pass through 2-FF synchronisers. All logic below uses the synchronised values (sync latency 2 cycles).
- The 32-bit counter saturates and never wraps. It resets to 0 on every state entry.
- FSM:
  - IDLE: waits for ctrl=1. On ctrl=1, capture data into d_cap and go to QUAL.
  - QUAL: counter increments.
    - ctrl=0 before counter reaches MIN_HIGH: runt error, go to GAP.
    - data differs from d_cap: unstable error, go to GAP.
    - counter reaches MIN_HIGH: accept the digit, go to HOLD.
  - HOLD: ctrl still high, data is ignored.
    - ctrl=0: go to GAP.
    - counter > MAX_HIGH: stuck error, go to STUCK.
  - STUCK: waits for ctrl=0, then goes to GAP. No further errors are raised while in STUCK.
  - GAP: ctrl=0 must last MIN_LOW cycles, then go to IDLE.
    - ctrl=1 before MIN_LOW: the counter restarts and the FSM stays in GAP. This is not an error; the strobe is ignored.
- Accept cycle:
  - num <= {0,d_cap} and valid pulses.
  - code shifts left 3 bits with d_cap appended at the LSB end. digit_count increments.
  - When digit_count reaches CODE_LEN: code_valid pulses in the same cycle as valid, and digit_count returns to 0. code holds its value until the next accept.
- Value 7 is never sent; the sender maps out-of-range digits to 0. If 7 is received it is accepted as-is. Filtering 7 is left to downstream logic.
- error pulses for 1 cycle and err_code updates in the same cycle. Any error also clears digit_count, discarding the partial code. code is unchanged.
- clear:
  - clear=1 sets digit_count to 0 and suppresses code_valid that cycle.
  - If clear and an accept occur in the same cycle, clear wins for digit_count. valid and num still update.
  - clear does not affect the FSM.
- Reset asserted mid-digit aborts the FSM to IDLE. If controlIn is still high after release, the FSM enters QUAL on the next synchronised high. A strobe cut short this way can yield a runt error.
- Total latency, strobe rising edge to valid: 2 + MIN_HIGH + 1 cycles.

Decomposition:
- Shared package holds: the FSM state encoding (IDLE, QUAL, HOLD, STUCK, GAP), the err_code constants, and HOLD_TIME so that sender and receiver share one timing definition.
- One natural sub-module, sync2: a 2-FF synchroniser with async active-low reset, instantiated 4 times (or 1-bit x4).

Test Plan (HOLD_TIME=20, MIN_HIGH=10, MAX_HIGH=40, MIN_LOW=10, CODE_LEN=4):
1. Send 3,1,4,6 with controlIn high 20 / low 20 cycles -> four valid pulses with num=3,1,4,6; code_valid with the 4th, code=12'b011_001_100_110; digit_count 0.
2. Send 5, then hold controlIn high 6 cycles -> error, err_code=01, digit_count 1->0, no valid.
3. Hold controlIn high and change data at cycle 5 -> error, err_code=10, no valid; the next clean digit 2 is accepted.
4. Hold controlIn high 60 cycles with data 1 -> valid num=1 at ~cycle 13, error err_code=11 after cycle 40 in HOLD, exactly one error; normal digit afterwards accepted.
5. Send a digit with only a 4-cycle gap before the next strobe -> second strobe ignored, no valid, no error.
6. Deassert rst_n during QUAL of digit 2 -> outputs 0 immediately; after release, the remainder of the strobe gives a runt error; subsequent digits accepted normally.
